// File: rtl/mem_arbiter.sv
// Shares one fixed-latency BRAM port between the instruction fetcher and the load/store unit.
// Orders are latched per port, ties alternate round-robin, and read data returns to the owning port.
module mem_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_order,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_accepted,
    output logic              f_accessed,
    output logic [31:0]       f_rdata,
    input  logic              d_order,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_we,
    output logic              d_accepted,
    output logic              d_accessed,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              busy
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic       PORT_F = 1'b0;
    localparam logic       PORT_D = 1'b1;
    localparam logic [3:0] LAT_C  = 4'(LATENCY);

    state_t              state_q, state_d;
    logic                f_pend_q, f_pend_d, d_pend_q, d_pend_d;
    logic [ADDR_W-1:0]   f_addr_q, f_addr_d, d_addr_q, d_addr_d;
    logic [31:0]         d_wdata_q, d_wdata_d;
    logic [3:0]          d_we_q, d_we_d;
    logic                owner_q, owner_d, last_grant_q, last_grant_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                f_accepted_q, f_accepted_d, f_accessed_q, f_accessed_d;
    logic                d_accepted_q, d_accepted_d, d_accessed_q, d_accessed_d;
    logic [31:0]         f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic [3:0]          mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_din_q, mem_din_d;
    logic                f_live_s, d_live_s, f_cand_s, d_cand_s, grant_s;
    logic                f_cap_s, d_cap_s;

    // An order arriving while that port already has one pending is dropped.
    assign f_live_s = f_order & ~f_pend_q;
    assign d_live_s = d_order & ~d_pend_q;
    assign f_cand_s = f_pend_q | f_order;
    assign d_cand_s = d_pend_q | d_order;

    // Arbitration, request capture and access sequencing.
    always_comb begin
        state_d      = state_q;
        f_pend_d     = f_pend_q;
        f_addr_d     = f_addr_q;
        d_pend_d     = d_pend_q;
        d_addr_d     = d_addr_q;
        d_wdata_d    = d_wdata_q;
        d_we_d       = d_we_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 4'b0000;
        f_accepted_d = 1'b0;
        f_accessed_d = 1'b0;
        d_accepted_d = 1'b0;
        d_accessed_d = 1'b0;
        grant_s      = PORT_F;
        f_cap_s      = 1'b0;
        d_cap_s      = 1'b0;
        case (state_q)
            IDLE: begin
                grant_s = (f_cand_s && d_cand_s) ? ~last_grant_q : d_cand_s;
                if (f_cand_s || d_cand_s) begin
                    state_d      = WAIT;
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    cnt_d        = LAT_C;
                    mem_en_d     = 1'b1;
                    if (grant_s == PORT_F) begin
                        f_accepted_d = 1'b1;
                        f_pend_d     = 1'b0;
                        mem_addr_d   = f_live_s ? f_addr : f_addr_q;
                        mem_we_d     = 4'b0000;
                        mem_din_d    = 32'h0000_0000;
                        d_cap_s      = d_live_s;
                    end else begin
                        d_accepted_d = 1'b1;
                        d_pend_d     = 1'b0;
                        mem_addr_d   = d_live_s ? d_addr : d_addr_q;
                        mem_we_d     = d_live_s ? d_we : d_we_q;
                        mem_din_d    = d_live_s ? d_wdata : d_wdata_q;
                        d_we_d       = d_live_s ? d_we : d_we_q;
                        f_cap_s      = f_live_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Only the port not in service may queue a new order.
                f_cap_s = f_live_s && (owner_q == PORT_D);
                d_cap_s = d_live_s && (owner_q == PORT_F);
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (owner_q == PORT_F) begin
                        f_accessed_d = 1'b1;
                        f_rdata_d    = mem_dout;
                    end else begin
                        d_accessed_d = 1'b1;
                        d_rdata_d    = (d_we_q == 4'b0000) ? mem_dout : d_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (f_cap_s) begin
            f_pend_d = 1'b1;
            f_addr_d = f_addr;
        end else begin
            f_addr_d = f_addr_d;
        end
        if (d_cap_s) begin
            d_pend_d  = 1'b1;
            d_addr_d  = d_addr;
            d_wdata_d = d_wdata;
            d_we_d    = d_we;
        end else begin
            d_addr_d = d_addr_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            f_pend_q     <= 1'b0;
            f_addr_q     <= '0;
            d_pend_q     <= 1'b0;
            d_addr_q     <= '0;
            d_wdata_q    <= 32'h0000_0000;
            d_we_q       <= 4'b0000;
            owner_q      <= PORT_F;
            last_grant_q <= PORT_D;
            cnt_q        <= 4'd0;
            f_accepted_q <= 1'b0;
            f_accessed_q <= 1'b0;
            d_accepted_q <= 1'b0;
            d_accessed_q <= 1'b0;
            f_rdata_q    <= 32'h0000_0000;
            d_rdata_q    <= 32'h0000_0000;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_din_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            f_pend_q     <= f_pend_d;
            f_addr_q     <= f_addr_d;
            d_pend_q     <= d_pend_d;
            d_addr_q     <= d_addr_d;
            d_wdata_q    <= d_wdata_d;
            d_we_q       <= d_we_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            f_accepted_q <= f_accepted_d;
            f_accessed_q <= f_accessed_d;
            d_accepted_q <= d_accepted_d;
            d_accessed_q <= d_accessed_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

    assign f_accepted = f_accepted_q;
    assign f_accessed = f_accessed_q;
    assign f_rdata    = f_rdata_q;
    assign d_accepted = d_accepted_q;
    assign d_accessed = d_accessed_q;
    assign d_rdata    = d_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign busy       = (state_q == WAIT);
endmodule
